// File: rtl/axi_bridge_core_pkg.sv
// Shared types for the sample bridge: FSM encoding, burst type and store geometry.
package axi_bridge_core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } bridge_fsm;

  localparam logic [1:0] INCR      = 2'b01;
  localparam int         IDX_W     = 12;
  localparam int         SAMPLE_W  = 16;
  localparam int         RAM_W     = 32;
  localparam int         RAM_DEPTH = 4096;

endpackage

// File: rtl/axi_bridge_core_ram.sv
// Sample store, 4096 x 32, clocked on the falling edge so read data settles
// before the next rising edge of the bridge clock.
module ram
  import axi_bridge_core_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [RAM_W-1:0] i_wdata,
  output logic [RAM_W-1:0] o_rdata
);

  logic [RAM_W-1:0] mem [RAM_DEPTH];

  always_ff @(negedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/axi_bridge_core.sv
// Sample bridge: streams N samples from the read channel into RAM, waits for
// the external computation, then streams RAM[0..N-1] out on the write channel.
module axi_bridge_core
  import axi_bridge_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_ARVALID,
  input  logic [SAMPLE_W-1:0]   i_ARDATA,
  input  logic                  i_AWREADY,
  input  logic                  i_CALC_END,
  input  logic [IDX_W-1:0]      i_SAMPLES_NUMBER,
  input  logic [RAM_W-1:0]      i_DATA_FROM_RAM,
  output logic                  o_ARREADY,
  output logic [1:0]            o_ARBURST,
  output logic [1:0]            o_AWBURST,
  output logic                  o_AWVALID,
  output logic [DATA_WIDTH-1:0] o_AWDATA,
  output logic                  o_DATA_LOADED,
  output logic [SAMPLE_W-1:0]   o_SAMPLE_ram,
  output logic [IDX_W-1:0]      o_SAMPLE_INDEX_ram,
  output logic                  o_WRITE_ram,
  output logic                  o_READ_ram,
  output bridge_fsm             current_state
);

  // A beat transfers on a rising edge where valid and ready are both 1; the
  // producer holds its payload stable until that edge, and the consumer may
  // change ready freely.
  bridge_fsm        state_q, state_d;
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] n_q;
  logic             last_beat;
  logic             start;

  assign last_beat     = (index_q == n_q - 12'd1);
  assign start         = i_ARVALID && (i_SAMPLES_NUMBER != '0);
  assign o_ARBURST     = INCR;
  assign o_AWBURST     = INCR;
  assign current_state = state_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (i_ARVALID && last_beat) state_d = WAIT;
      WAIT:    if (i_CALC_END) state_d = WRITE;
      WRITE:   if (i_AWREADY && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The index is cleared on the last beat of each phase, so it never wraps
  // even for the maximum length of 4095.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      index_q <= '0;
      n_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          n_q     <= i_SAMPLES_NUMBER;
          index_q <= '0;
        end
        READ:    if (i_ARVALID) index_q <= last_beat ? '0 : index_q + 12'd1;
        WRITE:   if (i_AWREADY) index_q <= last_beat ? '0 : index_q + 12'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ARREADY          = 1'b0;
    o_AWVALID          = 1'b0;
    o_DATA_LOADED      = 1'b0;
    o_WRITE_ram        = 1'b0;
    o_READ_ram         = 1'b0;
    o_AWDATA           = '0;
    o_SAMPLE_ram       = '0;
    o_SAMPLE_INDEX_ram = '0;
    case (state_q)
      READ: begin
        o_ARREADY          = 1'b1;
        o_SAMPLE_INDEX_ram = index_q;
        if (i_ARVALID) begin
          o_WRITE_ram  = 1'b1;
          o_SAMPLE_ram = i_ARDATA;
        end
      end
      WAIT: o_DATA_LOADED = 1'b1;
      WRITE: begin
        o_READ_ram         = 1'b1;
        o_AWVALID          = 1'b1;
        o_SAMPLE_INDEX_ram = index_q;
        o_AWDATA           = DATA_WIDTH'(i_DATA_FROM_RAM);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_bridge_core.sv
// Bench for the sample bridge wired to its RAM: loads, waits and unloads
// random transfers and checks every cycle against a queue-based model.
module tb_axi_bridge_core;
  import axi_bridge_core_pkg::*;

  localparam int W = 32;

  logic              i_clk;
  logic              i_rstn;
  logic              i_ARVALID;
  logic [15:0]       i_ARDATA;
  logic              i_AWREADY;
  logic              i_CALC_END;
  logic [11:0]       i_SAMPLES_NUMBER;
  logic [31:0]       i_DATA_FROM_RAM;
  logic              o_ARREADY;
  logic [1:0]        o_ARBURST;
  logic [1:0]        o_AWBURST;
  logic              o_AWVALID;
  logic [W-1:0]      o_AWDATA;
  logic              o_DATA_LOADED;
  logic [15:0]       o_SAMPLE_ram;
  logic [11:0]       o_SAMPLE_INDEX_ram;
  logic              o_WRITE_ram;
  logic              o_READ_ram;
  bridge_fsm         current_state;

  int compared;
  int mismatched;
  logic [W-1:0] exp_q[$];

  axi_bridge_core #(.DATA_WIDTH(W)) dut (
    .i_clk              (i_clk),
    .i_rstn             (i_rstn),
    .i_ARVALID          (i_ARVALID),
    .i_ARDATA           (i_ARDATA),
    .i_AWREADY          (i_AWREADY),
    .i_CALC_END         (i_CALC_END),
    .i_SAMPLES_NUMBER   (i_SAMPLES_NUMBER),
    .i_DATA_FROM_RAM    (i_DATA_FROM_RAM),
    .o_ARREADY          (o_ARREADY),
    .o_ARBURST          (o_ARBURST),
    .o_AWBURST          (o_AWBURST),
    .o_AWVALID          (o_AWVALID),
    .o_AWDATA           (o_AWDATA),
    .o_DATA_LOADED      (o_DATA_LOADED),
    .o_SAMPLE_ram       (o_SAMPLE_ram),
    .o_SAMPLE_INDEX_ram (o_SAMPLE_INDEX_ram),
    .o_WRITE_ram        (o_WRITE_ram),
    .o_READ_ram         (o_READ_ram),
    .current_state      (current_state)
  );

  ram u_ram (
    .i_clk   (i_clk),
    .i_we    (o_WRITE_ram),
    .i_re    (o_READ_ram),
    .i_addr  (o_SAMPLE_INDEX_ram),
    .i_wdata ({16'h0000, o_SAMPLE_ram}),
    .o_rdata (i_DATA_FROM_RAM)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
    #1;
  endtask

  // {arready, awvalid, data_loaded, write_ram, read_ram}
  function automatic logic [4:0] ctl();
    return {o_ARREADY, o_AWVALID, o_DATA_LOADED, o_WRITE_ram, o_READ_ram};
  endfunction

  // driver tasks with inline checks
  task automatic run_load(input int n, input bit toggle, input bit incr, input string name);
    int accepted;
    int cyc;
    logic v;
    logic [15:0] base;
    logic [15:0] data;
    exp_q.delete();
    base = 16'($urandom);
    i_SAMPLES_NUMBER = 12'(n);
    i_ARVALID = 1'b1;
    i_ARDATA = 16'($urandom);
    mid();
    compared++;
    if (current_state !== IDLE || ctl() !== 5'b00000) begin
      mismatched++;
      $display("FAIL %s_start: state=%s ctl=%b need IDLE ctl=00000", name, current_state.name(), ctl());
    end
    step();
    i_SAMPLES_NUMBER = 12'($urandom);
    accepted = 0;
    cyc = 0;
    while (accepted < n && cyc < 3 * n + 20) begin
      v = toggle ? cyc[0] : 1'b1;
      data = incr ? base + 16'(accepted) : 16'($urandom);
      i_ARVALID = v;
      i_ARDATA = data;
      i_CALC_END = 1'($urandom);
      i_AWREADY = 1'($urandom);
      mid();
      compared++;
      if (current_state !== READ || ctl() !== {1'b1, 1'b0, 1'b0, v, 1'b0}) begin
        mismatched++;
        $display("FAIL %s_read_ctl: state=%s ctl=%b need READ ctl=%b", name, current_state.name(), ctl(), {1'b1, 1'b0, 1'b0, v, 1'b0});
      end
      if (v) begin
        compared++;
        if (o_SAMPLE_ram !== data || o_SAMPLE_INDEX_ram !== 12'(accepted)) begin
          mismatched++;
          $display("FAIL %s_store: sample=%h addr=%0d need sample=%h addr=%0d", name, o_SAMPLE_ram, o_SAMPLE_INDEX_ram, data, accepted);
        end
      end
      step();
      if (v) begin
        exp_q.push_back(W'(data));
        accepted++;
      end
      cyc++;
    end
    if (accepted < n) begin
      compared++;
      mismatched++;
      $display("FAIL %s_load_timeout: accepted=%0d need %0d", name, accepted, n);
    end
    i_ARVALID = 1'($urandom);
    i_CALC_END = 1'b0;
    i_AWREADY = 1'($urandom);
    mid();
    compared++;
    if (current_state !== WAIT || ctl() !== 5'b00100) begin
      mismatched++;
      $display("FAIL %s_loaded: state=%s ctl=%b need WAIT ctl=00100", name, current_state.name(), ctl());
    end
    step();
  endtask

  task automatic run_wait(input int hold, input string name);
    for (int k = 0; k < hold; k++) begin
      i_CALC_END = 1'b0;
      i_ARVALID = 1'($urandom);
      i_AWREADY = 1'($urandom);
      mid();
      compared++;
      if (current_state !== WAIT || ctl() !== 5'b00100) begin
        mismatched++;
        $display("FAIL %s_hold: cycle=%0d state=%s ctl=%b need WAIT ctl=00100", name, k, current_state.name(), ctl());
      end
      step();
    end
    i_CALC_END = 1'b1;
    mid();
    compared++;
    if (current_state !== WAIT) begin
      mismatched++;
      $display("FAIL %s_calc_end: state=%s need WAIT", name, current_state.name());
    end
    step();
    i_CALC_END = 1'b0;
  endtask

  task automatic run_unload(input int n, input int mode, input string name);
    int beats;
    int cyc;
    logic r;
    beats = 0;
    cyc = 0;
    while (beats < n && cyc < 4 * n + 20) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = cyc[0];
        default: r = 1'($urandom);
      endcase
      i_AWREADY = r;
      i_ARVALID = 1'($urandom);
      i_CALC_END = 1'($urandom);
      mid();
      compared++;
      if (current_state !== WRITE || ctl() !== 5'b01001 || o_SAMPLE_INDEX_ram !== 12'(beats)) begin
        mismatched++;
        $display("FAIL %s_write_ctl: state=%s ctl=%b addr=%0d need WRITE ctl=01001 addr=%0d", name, current_state.name(), ctl(), o_SAMPLE_INDEX_ram, beats);
      end
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL %s_awdata: beat=%0d got=%h but no beat expected", name, beats, o_AWDATA);
      end else if (o_AWDATA !== exp_q[0]) begin
        mismatched++;
        $display("FAIL %s_awdata: beat=%0d got=%h need=%h", name, beats, o_AWDATA, exp_q[0]);
      end
      step();
      if (r) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        beats++;
      end
      cyc++;
    end
    if (beats < n) begin
      compared++;
      mismatched++;
      $display("FAIL %s_unload_timeout: beats=%0d need %0d", name, beats, n);
    end
    i_AWREADY = 1'b0;
    i_ARVALID = 1'b0;
    i_CALC_END = 1'b0;
    mid();
    compared++;
    if (current_state !== IDLE || ctl() !== 5'b00000) begin
      mismatched++;
      $display("FAIL %s_done: state=%s ctl=%b need IDLE ctl=00000", name, current_state.name(), ctl());
    end
    step();
  endtask

  // scenarios
  task automatic test_reset();
    i_rstn = 1'b0;
    i_ARVALID = 1'b0;
    i_ARDATA = '0;
    i_AWREADY = 1'b0;
    i_CALC_END = 1'b0;
    i_SAMPLES_NUMBER = '0;
    #3;
    compared++;
    if (current_state !== IDLE || ctl() !== 5'b00000 || o_AWDATA !== '0 || o_SAMPLE_ram !== '0 ||
        o_SAMPLE_INDEX_ram !== '0 || o_ARBURST !== 2'b01 || o_AWBURST !== 2'b01) begin
      mismatched++;
      $display("FAIL reset_values: state=%s ctl=%b awdata=%h sample=%h addr=%h bursts=%b/%b need all zero, bursts 01",
               current_state.name(), ctl(), o_AWDATA, o_SAMPLE_ram, o_SAMPLE_INDEX_ram, o_ARBURST, o_AWBURST);
    end
    step();
    i_ARVALID = 1'b1;
    i_SAMPLES_NUMBER = 12'd5;
    i_CALC_END = 1'b1;
    i_AWREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      compared++;
      if (current_state !== IDLE || ctl() !== 5'b00000) begin
        mismatched++;
        $display("FAIL reset_hold: state=%s ctl=%b need IDLE ctl=00000", current_state.name(), ctl());
      end
      step();
    end
    i_rstn = 1'b1;
    i_ARVALID = 1'b0;
    i_CALC_END = 1'b0;
    i_AWREADY = 1'b0;
    step();
  endtask

  task automatic test_basic();
    run_load(10, 1'b0, 1'b1, "basic");
    run_wait(20, "basic");
    run_unload(10, 1, "basic");
  endtask

  task automatic test_zero_length();
    i_SAMPLES_NUMBER = '0;
    i_ARVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_ARDATA = 16'($urandom);
      mid();
      compared++;
      if (current_state !== IDLE || ctl() !== 5'b00000) begin
        mismatched++;
        $display("FAIL zero_len: state=%s ctl=%b need IDLE ctl=00000", current_state.name(), ctl());
      end
      step();
    end
    i_ARVALID = 1'b0;
  endtask

  task automatic test_toggle_valid();
    run_load(4, 1'b1, 1'b0, "toggle");
    run_wait(0, "toggle");
    run_unload(4, 0, "toggle");
  endtask

  task automatic test_reset_mid_transfer();
    i_SAMPLES_NUMBER = 12'd10;
    i_ARVALID = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      i_ARDATA = 16'($urandom);
      step();
    end
    #2;
    i_rstn = 1'b0;
    #1;
    compared++;
    if (current_state !== IDLE || ctl() !== 5'b00000 || o_AWDATA !== '0 || o_SAMPLE_ram !== '0 || o_SAMPLE_INDEX_ram !== '0) begin
      mismatched++;
      $display("FAIL abort_async: state=%s ctl=%b sample=%h addr=%h need IDLE and all zero",
               current_state.name(), ctl(), o_SAMPLE_ram, o_SAMPLE_INDEX_ram);
    end
    step();
    i_rstn = 1'b1;
    i_ARVALID = 1'b0;
    step();
    run_load(3, 1'b0, 1'b0, "restart");
    run_wait(2, "restart");
    run_unload(3, 2, "restart");
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 40);
      run_load(n, 1'($urandom), 1'b0, "random");
      run_wait($urandom_range(0, 5), "random");
      run_unload(n, $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_max_length();
    run_load(4095, 1'b0, 1'b0, "maxlen");
    run_wait(1, "maxlen");
    run_unload(4095, 2, "maxlen");
  endtask

  // final report
  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_zero_length();
    test_toggle_valid();
    test_reset_mid_transfer();
    test_random();
    test_max_length();
    compared++;
    if (o_ARBURST !== INCR || o_AWBURST !== INCR) begin
      mismatched++;
      $display("FAIL bursts_end: ar=%b aw=%b need 01", o_ARBURST, o_AWBURST);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_bridge_core.md
AXI_BRIDGE_CORE -- requirements
Module: axi_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the write-data output o_AWDATA.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rstn  input  1  asynchronous, active-low reset.
REQ-004 i_ARVALID  input  1  read-channel sample valid.
REQ-005 i_ARDATA  input  16  incoming sample.
REQ-006 i_AWREADY  input  1  write-channel sink ready.
REQ-007 i_CALC_END  input  1  external computation finished.
REQ-008 i_SAMPLES_NUMBER  input  12  transfer length N.
REQ-009 i_DATA_FROM_RAM  input  32  RAM read data.
REQ-010 o_ARREADY  output  1  bridge accepts a sample.
REQ-011 o_ARBURST, o_AWBURST  output  2 each  burst type, constant 2'b01 (INCR).
REQ-012 o_AWVALID  output  1  write data valid.
REQ-013 o_AWDATA  output  DATA_WIDTH  write data; low bits of i_DATA_FROM_RAM, zero-extended if DATA_WIDTH > 32.
REQ-014 o_DATA_LOADED  output  1  all N samples stored.
REQ-015 o_SAMPLE_ram  output  16  RAM write data.
REQ-016 o_SAMPLE_INDEX_ram  output  12  RAM address.
REQ-017 o_WRITE_ram, o_READ_ram  output  1 each  RAM write/read strobes.
REQ-018 current_state  output  bridge_fsm  present FSM state.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WAIT, WRITE.
REQ-020 In IDLE, when i_ARVALID=1 and i_SAMPLES_NUMBER != 0, the bridge SHALL latch N and go to READ with index 0; when N = 0 it SHALL stay in IDLE.
REQ-021 In READ, o_ARREADY SHALL be 1; each cycle with i_ARVALID=1 SHALL combinationally drive o_WRITE_ram=1, o_SAMPLE_ram=i_ARDATA and o_SAMPLE_INDEX_ram=index, then increment the index at the clock edge.
REQ-022 In READ, cycles with i_ARVALID=0 SHALL drive o_WRITE_ram=0 and hold the index.
REQ-023 The accepted beat at index N-1 SHALL move the FSM to WAIT and clear the index.
REQ-024 In WAIT, o_DATA_LOADED SHALL be 1 and o_ARREADY 0; i_CALC_END=1 SHALL move the FSM to WRITE.
REQ-025 In WRITE, the bridge SHALL drive o_READ_ram=1 and o_SAMPLE_INDEX_ram=index, and SHALL drive o_AWVALID=1 with o_AWDATA taken combinationally from i_DATA_FROM_RAM.
REQ-026 The RAM contract for REQ-025: the RAM updates on the falling edge, so its data is valid before the next rising edge.
REQ-027 In WRITE, the index SHALL advance only when o_AWVALID and i_AWREADY are both 1; o_AWDATA and the index SHALL hold while i_AWREADY=0.
REQ-028 The handshake at index N-1 SHALL return the FSM to IDLE.
REQ-029 i_CALC_END outside WAIT and i_ARVALID outside IDLE/READ SHALL be ignored; i_AWREADY outside WRITE SHALL be ignored.
REQ-030 A change of i_SAMPLES_NUMBER after latching SHALL NOT affect the running transfer.
REQ-031 The index SHALL be 12-bit unsigned; N = 4095 is the maximum length, and the index never wraps within a transfer.

Reset
REQ-032 When i_rstn=0, the bridge SHALL asynchronously force IDLE, index 0 and latched N 0.
REQ-033 During reset, o_ARREADY, o_AWVALID, o_DATA_LOADED, o_WRITE_ram and o_READ_ram SHALL be 0, and o_AWDATA, o_SAMPLE_ram and o_SAMPLE_INDEX_ram SHALL be 0.
REQ-034 The burst outputs SHALL be 2'b01 at all times, including during reset.
REQ-035 Reset asserted mid-transfer SHALL abort it; RAM contents are not cleared.

Structure
REQ-036 The enum bridge_fsm (IDLE, READ, WAIT, WRITE) and the burst constant INCR = 2'b01 SHALL reside in a shared package imported by the bridge and its benches.
REQ-037 axi_bridge SHALL contain no sub-module.
REQ-038 The sample store SHALL be a separate module, ram, clocked on the inverted clock, 4096 x 32.

Verification
REQ-039 Reset released, N=10, i_ARVALID=1 with incrementing i_ARDATA -> 10 writes to addresses 0..9; then WAIT with o_DATA_LOADED=1.
REQ-040 N=0 with i_ARVALID=1 -> FSM remains IDLE and o_ARREADY stays 0.
REQ-041 N=4 with i_ARVALID toggling every cycle -> exactly 4 write strobes at addresses 0..3, with no address skipped.
REQ-042 In WAIT with i_CALC_END=0 for 20 cycles -> FSM stays in WAIT; i_CALC_END=1 -> WRITE on the next edge.
REQ-043 WRITE with N=10 and i_AWREADY low every other cycle -> 10 beats carrying RAM[0..9] in order, each held stable while stalled; then IDLE.
REQ-044 i_rstn dropped at READ index 5 -> immediate IDLE with all outputs zero; a new transfer restarts at index 0.
